cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 16 +
 rtl/cache_ctrl_sat_counter.sv | 22 ++
 rtl/cache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller: FSM state encoding and statistics width.
package cache_ctrl_pkg;

  localparam int unsigned CNTW = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WAIT   = 3'd2,
    MISS   = 3'd3,
    FILL   = 3'd4,
    WRITE  = 3'd5,
    RESP   = 3'd6
  } state_e;

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; a clear wins over a same-cycle increment.
module sat_counter
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned W = CNTW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, write-allocate cache controller sequencing an external cache and backing memory.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned DW     = 64,
  parameter int unsigned AW     = 64,
  parameter int unsigned INDEXW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_hit,
  output logic            cache_valid,
  output logic            cache_write,
  output logic [AW-1:0]   cache_addr,
  output logic [DW-1:0]   cache_wdata,
  input  logic [DW-1:0]   cache_rdata,
  input  logic            cache_ready,
  input  logic            cache_hit,
  output logic            mem_valid,
  output logic            mem_write,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            stat_clear,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  state_e        state, state_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic [DW-1:0] data_q, data_n;
  logic          enter_write;
  logic          hit_inc, miss_inc;

  logic          req_ready_n, rsp_valid_n, rsp_hit_n;
  logic [DW-1:0] rsp_rdata_n;
  logic          cache_valid_n, cache_write_n;
  logic [AW-1:0] cache_addr_n;
  logic [DW-1:0] cache_wdata_n;
  logic          mem_valid_n, mem_write_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n;

  // Next state plus next value of every registered output, derived from the state being entered.
  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    data_n      = data_q;
    rsp_hit_n   = 1'b0;
    rsp_rdata_n = '0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_n  = req_addr;
          wdata_n = req_wdata;
          state_n = req_write ? WRITE : LOOKUP;
        end
      end
      LOOKUP: state_n = WAIT;
      WAIT: begin
        if (cache_ready) begin
          if (cache_hit) begin
            state_n     = RESP;
            rsp_hit_n   = 1'b1;
            rsp_rdata_n = cache_rdata;
            hit_inc     = 1'b1;
          end else begin
            state_n = MISS;
          end
        end
      end
      MISS: begin
        if (mem_ready) begin
          data_n  = mem_rdata;
          state_n = FILL;
        end
      end
      FILL: begin
        state_n     = RESP;
        rsp_rdata_n = data_q;
        miss_inc    = 1'b1;
      end
      WRITE: begin
        if (mem_ready) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // The cache sees a write only in the first WRITE cycle; memory holds it until accepted.
    enter_write   = (state == IDLE) && (state_n == WRITE);
    req_ready_n   = (state_n == IDLE);
    rsp_valid_n   = (state_n == RESP);
    cache_valid_n = (state_n == LOOKUP) || (state_n == FILL) || enter_write;
    cache_write_n = (state_n == FILL) || enter_write;
    cache_addr_n  = cache_valid_n ? {addr_n[AW-1:INDEXW], addr_n[INDEXW-1:0]} : '0;
    cache_wdata_n = (state_n == FILL) ? data_n : (enter_write ? wdata_n : '0);
    mem_valid_n   = (state_n == MISS) || (state_n == WRITE);
    mem_write_n   = (state_n == WRITE);
    mem_addr_n    = mem_valid_n ? addr_n : '0;
    mem_wdata_n   = mem_write_n ? wdata_n : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_hit     <= 1'b0;
      cache_valid <= 1'b0;
      cache_write <= 1'b0;
      cache_addr  <= '0;
      cache_wdata <= '0;
      mem_valid   <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      data_q      <= data_n;
      req_ready   <= req_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_hit     <= rsp_hit_n;
      cache_valid <= cache_valid_n;
      cache_write <= cache_write_n;
      cache_addr  <= cache_addr_n;
      cache_wdata <= cache_wdata_n;
      mem_valid   <= mem_valid_n;
      mem_write   <= mem_write_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
    end
  end

  sat_counter #(.W(CNTW)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (stat_clear),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNTW)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (stat_clear),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: emulated cache and memory, a tag/data reference model, per-cycle counter checks.
module tb_cache_ctrl;

  localparam int unsigned DW     = 64;
  localparam int unsigned AW     = 64;
  localparam int unsigned INDEXW = 8;
  localparam int unsigned NSET   = 1 << INDEXW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_hit;
  logic [DW-1:0] rsp_rdata;
  logic          cache_valid, cache_write;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic [DW-1:0] cache_rdata = '0;
  logic          cache_ready = 1'b0, cache_hit = 1'b0;
  logic          mem_valid, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stat_clear = 1'b0;
  logic [31:0]   hit_count, miss_count;

  logic          sc_clear = 1'b0, sc_inc = 1'b0;
  logic [2:0]    sc_count;

  always #5 clk = ~clk;

  cache_ctrl #(.DW(DW), .AW(AW), .INDEXW(INDEXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
    .cache_valid(cache_valid), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_ready(cache_ready),
    .cache_hit(cache_hit),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stat_clear(stat_clear), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow instance so saturation is reachable in a few cycles.
  sat_counter #(.W(3)) u_sat (
    .clk(clk), .rst(rst), .clear(sc_clear), .inc(sc_inc), .count(sc_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_init(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  // Reference model: what memory holds and which address each set should contain.
  logic [63:0] ref_mem [logic [63:0]];
  bit          ref_vld [NSET];
  logic [63:0] ref_tag [NSET];
  logic [31:0] hc_exp = '0, mc_exp = '0;
  bit          pend = 1'b0, pend_read = 1'b0, pend_hit = 1'b0;

  function automatic logic [63:0] ref_mem_get(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_init(a);
  endfunction

  // Fixtures: external cache (2-cycle response) and backing memory.
  typedef struct packed {logic v; logic w; logic [63:0] a; logic [63:0] d;} creq_t;
  creq_t       p1 = '0, p2 = '0;
  bit          c_vld  [NSET];
  logic [63:0] c_tag  [NSET];
  logic [63:0] c_data [NSET];
  logic [63:0] fx_mem [logic [63:0]];
  int          mem_lat = 2;
  bit          mem_hold = 1'b0;
  int          mv_cnt = 0;

  always @(posedge clk) begin
    creq_t cur;
    int    idx;
    #1;
    if (rsp_valid && pend && pend_read) begin
      if (pend_hit) hc_exp = hc_exp + 32'd1;
      else          mc_exp = mc_exp + 32'd1;
    end
    if (rst || stat_clear) begin
      hc_exp = '0;
      mc_exp = '0;
    end
    check("hit_count", hit_count, hc_exp);
    check("miss_count", miss_count, mc_exp);
    if (!pend) check("idle_quiet", {cache_valid, mem_valid, rsp_valid}, 0);

    cur = {cache_valid, cache_write, cache_addr, cache_wdata};
    cache_ready = 1'b0;
    cache_hit   = 1'b0;
    cache_rdata = '0;
    if (p2.v) begin
      idx = int'(p2.a[INDEXW-1:0]);
      cache_ready = 1'b1;
      if (p2.w) begin
        c_vld[idx]  = 1'b1;
        c_tag[idx]  = p2.a;
        c_data[idx] = p2.d;
      end else begin
        cache_hit   = c_vld[idx] && (c_tag[idx] == p2.a);
        cache_rdata = cache_hit ? c_data[idx] : 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
    p2 = p1;
    p1 = cur;

    if (mem_valid) begin
      mem_rdata = fx_mem.exists(mem_addr) ? fx_mem[mem_addr] : mem_init(mem_addr);
      if (mem_hold || mv_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        if (mem_write) fx_mem[mem_addr] = mem_wdata;
        mv_cnt = 0;
      end else begin
        mem_ready = 1'b0;
        mv_cnt++;
      end
    end else begin
      mem_ready = mem_hold;
      mem_rdata = '0;
      mv_cnt    = 0;
    end
  end

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    ref_mem[a] = d;
    fx_mem[a]  = d;
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
  endtask

  // One request from a negedge; checks the response against the reference model.
  task automatic do_req(input bit wr, input logic [63:0] a, input logic [63:0] wd, input int clr_n,
                        output bit got_hit, output logic [63:0] got_rd, output int mv,
                        output logic [63:0] mw);
    int          idx, n, cv, lat, exp_mv, exp_cv;
    bit          exp_hit, done, addr_bad;
    logic [63:0] exp_rd;
    idx     = int'(a[INDEXW-1:0]);
    exp_hit = !wr && ref_vld[idx] && (ref_tag[idx] == a);
    exp_rd  = wr ? 64'd0 : ref_mem_get(a);
    if (wr) ref_mem[a] = wd;
    ref_vld[idx] = 1'b1;
    ref_tag[idx] = a;
    exp_mv = exp_hit ? 0 : (mem_hold ? 1 : mem_lat + 1);
    exp_cv = (wr || exp_hit) ? 1 : 2;

    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    pend = 1'b1; pend_read = !wr; pend_hit = exp_hit;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};

    n = 1; mv = 0; cv = 0; done = 1'b0; addr_bad = 1'b0; lat = 0;
    mw = '0; got_hit = 1'b0; got_rd = '0;
    while (!done && n < 200) begin
      stat_clear = (n == clr_n);
      if (mem_valid) begin
        mv++;
        if (mem_addr != a) addr_bad = 1'b1;
        if (mem_write) mw = mem_wdata;
      end
      if (cache_valid) begin
        cv++;
        if (cache_addr != a) addr_bad = 1'b1;
      end
      if (rsp_valid) begin
        done = 1'b1; lat = n - 1; got_hit = rsp_hit; got_rd = rsp_rdata;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    stat_clear = 1'b0;

    check("rsp_seen", done, 1);
    check("rsp_hit", got_hit, exp_hit);
    check("rsp_rdata", got_rd, exp_rd);
    check("mem_valid_cycles", mv, exp_mv);
    check("cache_valid_cycles", cv, exp_cv);
    check("req_addr_out", addr_bad, 0);
    if (wr) check("mem_wdata", mw, wd);
    if (exp_hit) check("hit_latency", lat, 3);
    @(negedge clk);
    pend = 1'b0;
    check("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    bit          h;
    logic [63:0] rd, mw, a;
    int          mv, n, r;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_hit, rsp_rdata}, 0);
    check("rst_cache", {cache_valid, cache_write, cache_addr}, 0);
    check("rst_mem", {mem_valid, mem_write, mem_addr}, 0);
    check("rst_wdata_out", cache_wdata | mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", req_ready, 1);

    // Cold miss with slow memory, then the same address hits.
    mem_lat = 2;
    preload(64'h1000, 64'hDEAD);
    do_req(1'b0, 64'h1000, 64'd0, 0, h, rd, mv, mw);
    check("miss_hit_flag", h, 0);
    check("miss_rdata", rd, 64'hDEAD);
    check("miss_count_1", miss_count, 32'd1);
    do_req(1'b0, 64'h1000, 64'd0, 0, h, rd, mv, mw);
    check("hit_flag", h, 1);
    check("hit_rdata", rd, 64'hDEAD);
    check("hit_count_1", hit_count, 32'd1);

    // Write-through then read hit with no memory traffic.
    do_req(1'b1, 64'h2008, 64'h55, 0, h, rd, mv, mw);
    check("write_mem_data", mw, 64'h55);
    check("write_rdata_zero", rd, 64'd0);
    do_req(1'b0, 64'h2008, 64'd0, 0, h, rd, mv, mw);
    check("wr_then_rd_hit", h, 1);
    check("wr_then_rd_data", rd, 64'h55);
    check("wr_then_rd_no_mem", mv, 0);

    // Index conflict evicts.
    clear_stats();
    do_req(1'b0, 64'h3010, 64'd0, 0, h, rd, mv, mw);
    do_req(1'b0, 64'h3010 + (64'd1 << INDEXW), 64'd0, 0, h, rd, mv, mw);
    check("conflict_miss", h, 0);
    do_req(1'b0, 64'h3010, 64'd0, 0, h, rd, mv, mw);
    check("evicted_miss", h, 0);
    check("miss_count_3", miss_count, 32'd3);

    // Zero-wait memory.
    mem_hold = 1'b1;
    do_req(1'b0, 64'h4000, 64'd0, 0, h, rd, mv, mw);
    check("zero_wait_read_mv", mv, 1);
    do_req(1'b1, 64'h4100, 64'hABCD_0123, 0, h, rd, mv, mw);
    check("zero_wait_write_mv", mv, 1);
    mem_hold = 1'b0;

    // Clear coincident with a hit wins.
    do_req(1'b0, 64'h2008, 64'd0, 3, h, rd, mv, mw);
    check("clear_hit_flag", h, 1);
    check("clear_vs_hit", hit_count, 32'd0);

    // Saturation on a narrow counter.
    sc_inc = 1'b1;
    repeat (10) @(negedge clk);
    check("sat_hold", sc_count, 3'd7);
    sc_clear = 1'b1;
    @(negedge clk);
    check("sat_clear_wins", sc_count, 3'd0);
    sc_inc = 1'b0; sc_clear = 1'b0;

    // Randomized traffic with conflicting addresses.
    for (int i = 0; i < 300; i++) begin
      a = 64'h8000 + 64'($urandom_range(0, 7)) + (64'($urandom_range(0, 1)) << INDEXW);
      mem_lat  = $urandom_range(0, 3);
      mem_hold = ($urandom_range(0, 7) == 0);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
      do_req(($urandom_range(0, 2) == 0), a, {$urandom, $urandom}, n, h, rd, mv, mw);
    end
    mem_hold = 1'b0;

    // Reset while waiting on memory abandons the read.
    mem_lat = 10;
    pend = 1'b1; pend_read = 1'b1; pend_hit = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h9A_BC00;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_miss_mem_valid", mem_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drops_mem_valid", mem_valid, 0);
    check("rst_drops_cache_valid", cache_valid, 0);
    check("rst_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_abort", req_ready, 1);
    check("counters_after_abort", {hit_count, miss_count}, 0);
    pend = 1'b0;
    r = 0;
    repeat (8) begin
      @(negedge clk);
      r += int'(rsp_valid);
    end
    check("no_rsp_after_abort", r, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
